fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single FIFO write port among NUM_REQ requesters.
- Each requester presents a valid/ready beat stream with an end-of-burst marker.
- The arbiter grants one requester at a time for up to MAX_BURST beats and drives wr_en/wdata into the FIFO, throttled by full.
- It sits entirely in the FIFO write-clock domain and also keeps beat and write-error counters.

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ burst requesters.
// Also keeps a wrapping beat counter and a saturating write-error counter.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     wr_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     full,
    input  logic                     wr_error,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [CNT_W-1:0]         err_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [IW-1:0]      g, sel;
    logic               accept, release_now;

    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_q[i]) g = IW'(i);
    end

    // Walk downward so the nearest valid requester after the pointer wins.
    always_comb begin
        sel = ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int j;
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (req_valid[j]) sel = IW'(j);
        end
    end

    assign req_ready   = grant_q & {NUM_REQ{~full & ~rst}};
    assign accept      = |(req_valid & req_ready);
    assign wr_en       = accept;
    assign wdata       = (grant_q != '0) ? req_data[g*WIDTH +: WIDTH] : '0;
    assign grant       = grant_q;
    assign busy        = (state_q == BURST);
    assign beat_cnt    = beat_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign release_now = (accept & (req_last[g] | (bcnt_q == BW'(MAX_BURST - 1)))) | ~req_valid[g];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        bcnt_d     = bcnt_q;
        beat_cnt_d = beat_cnt_q + CNT_W'(accept);
        err_cnt_d  = (wr_error & ~&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                state_d = BURST;
                bcnt_d  = '0;
            end
            BURST: begin
                bcnt_d = accept ? bcnt_q + 1'b1 : bcnt_q;
                if (release_now) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = g;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= IW'(NUM_REQ - 1);
            bcnt_q     <= '0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            bcnt_q     <= bcnt_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for the FIFO write-port arbiter.
module tb_fifo_wr_arbiter;
    logic        wr_clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready, grant;
    logic [31:0] req_data;
    logic        full, wr_error, wr_en, busy;
    logic [7:0]  wdata;
    logic [15:0] beat_cnt, err_cnt;
    logic [3:0]  s_ready, s_grant, s_beat, s_err;
    logic        s_wr_en, s_busy;
    logic [7:0]  s_wdata;
    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter dut (
        .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .full(full), .wr_error(wr_error),
        .wr_en(wr_en), .wdata(wdata), .grant(grant), .busy(busy),
        .beat_cnt(beat_cnt), .err_cnt(err_cnt)
    );

    fifo_wr_arbiter #(.CNT_W(4)) dut_s (
        .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(s_ready), .full(full), .wr_error(wr_error),
        .wr_en(s_wr_en), .wdata(s_wdata), .grant(s_grant), .busy(s_busy),
        .beat_cnt(s_beat), .err_cnt(s_err)
    );

    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        checks++;
        assert ($onehot0(grant) && !(wr_en && full)) else begin
            errors++;
            $error("FAIL invariant grant=%b wr_en=%b full=%b", grant, wr_en, full);
        end
    end

    task automatic tick;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; req_valid = 0; req_last = 0; req_data = 0; full = 0; wr_error = 0;
        tick; tick;
        #1;
        chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_wr_en", wr_en, 0);
        chk("rst_wdata", wdata, 0); chk("rst_beat", beat_cnt, 0); chk("rst_err", err_cnt, 0);
        chk("rst_ready", req_ready, 0);
        rst = 0;

        // 1: requester 2 three-beat burst
        tick;
        req_valid = 4'b0100; req_data[23:16] = 8'hA1; #1;
        chk("t1_pre_grant", grant, 0); chk("t1_pre_wr_en", wr_en, 0);
        tick; #1;
        chk("t1_grant", grant, 4'b0100); chk("t1_busy", busy, 1); chk("t1_ready", req_ready, 4'b0100);
        chk("t1_wr_en0", wr_en, 1); chk("t1_wdata0", wdata, 8'hA1);
        tick; req_data[23:16] = 8'hA2; #1;
        chk("t1_wr_en1", wr_en, 1); chk("t1_wdata1", wdata, 8'hA2);
        tick; req_data[23:16] = 8'hA3; req_last = 4'b0100; #1;
        chk("t1_wr_en2", wr_en, 1); chk("t1_wdata2", wdata, 8'hA3);
        tick; req_valid = 0; req_last = 0; #1;
        chk("t1_rel_grant", grant, 0); chk("t1_rel_busy", busy, 0); chk("t1_beat", beat_cnt, 3);

        // 2: all four requesters continuously valid, burst-length limited
        rst = 1; tick; rst = 0;
        req_valid = 4'b1111; req_data = 32'h44332211;
        for (int r = 0; r < 4; r++) begin
            tick;
            for (int b = 0; b < 4; b++) begin
                #1;
                chk("t2_grant", grant, 4'b0001 << r); chk("t2_wr_en", wr_en, 1);
                chk("t2_wdata", wdata, (r + 1) * 8'h11);
                tick;
            end
            #1;
            chk("t2_idle_grant", grant, 0); chk("t2_idle_wr_en", wr_en, 0);
        end
        chk("t2_beat", beat_cnt, 16);
        tick; #1;
        chk("t2_wrap_grant", grant, 4'b0001);
        req_valid = 0;
        tick; #1;
        chk("t2_drop_grant", grant, 0); chk("t2_beat_after", beat_cnt, 16);

        // 3: full stall mid-burst for requester 0
        req_valid = 4'b0001; req_data = 32'h000000B1;
        tick; #1;
        chk("t3_grant", grant, 4'b0001); chk("t3_wdata0", wdata, 8'hB1); chk("t3_wr_en0", wr_en, 1);
        tick; req_data[7:0] = 8'hB2; #1;
        chk("t3_wdata1", wdata, 8'hB2); chk("t3_wr_en1", wr_en, 1);
        tick; full = 1; req_data[7:0] = 8'hB3;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t3_stall_wr_en", wr_en, 0); chk("t3_stall_ready", req_ready, 0);
            chk("t3_stall_grant", grant, 4'b0001);
            tick;
        end
        full = 0; #1;
        chk("t3_wdata2", wdata, 8'hB3); chk("t3_wr_en2", wr_en, 1);
        tick; req_data[7:0] = 8'hB4; #1;
        chk("t3_wdata3", wdata, 8'hB4); chk("t3_wr_en3", wr_en, 1);
        tick; req_valid = 0; #1;
        chk("t3_rel_grant", grant, 0); chk("t3_beat", beat_cnt, 20);

        // 4: requester 1 drops after one beat, requester 3 waiting
        req_valid = 4'b1010; req_data = 32'hD3_00_C1_00;
        tick; #1;
        chk("t4_grant1", grant, 4'b0010); chk("t4_wdata", wdata, 8'hC1); chk("t4_wr_en", wr_en, 1);
        tick; req_valid = 4'b1000; #1;
        chk("t4_drop_wr_en", wr_en, 0); chk("t4_drop_grant", grant, 4'b0010);
        tick; #1;
        chk("t4_idle", grant, 0);
        tick; #1;
        chk("t4_grant3", grant, 4'b1000);
        req_valid = 0;
        tick; #1;
        chk("t4_rel", grant, 0); chk("t4_beat", beat_cnt, 21);

        // 5: error counter, plus saturation on the narrow instance
        for (int p = 0; p < 3; p++) begin
            wr_error = 1; tick; wr_error = 0; tick;
        end
        chk("t5_err3", err_cnt, 3); chk("t5_s_err3", s_err, 3);
        wr_error = 1;
        for (int p = 0; p < 20; p++) tick;
        wr_error = 0; tick;
        chk("t5_err23", err_cnt, 23); chk("t5_s_sat", s_err, 4'hF);

        // 6: reset mid-burst of requester 2
        req_valid = 4'b0100; req_data = 32'h00D10000;
        tick; #1;
        chk("t6_grant", grant, 4'b0100); chk("t6_wr_en", wr_en, 1);
        tick; rst = 1; req_data[23:16] = 8'hD2; #1;
        chk("t6_rst_wr_en", wr_en, 0); chk("t6_rst_ready", req_ready, 0);
        tick; rst = 0; req_valid = 4'b1001; #1;
        chk("t6_grant0", grant, 0); chk("t6_wr_en0", wr_en, 0);
        chk("t6_beat", beat_cnt, 0); chk("t6_err", err_cnt, 0);
        tick; #1;
        chk("t6_next_grant", grant, 4'b0001);
        req_valid = 0;
        tick; tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
